// File: rtl/ahb_pkg.sv
// ahb_pkg: AHB transfer/burst encodings, arbiter states and burst length helper
package ahb_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, BUSY = 2'd1, NONSEQ = 2'd2, SEQ = 2'd3} htrans_e;
  typedef enum logic [2:0] {
    SINGLE = 3'd0, INCR = 3'd1, WRAP4 = 3'd2, INCR4 = 3'd3,
    WRAP8 = 3'd4, INCR8 = 3'd5, WRAP16 = 3'd6, INCR16 = 3'd7
  } hburst_e;
  typedef enum logic [1:0] {PARK = 2'd0, GRANT = 2'd1, BURST = 2'd2, LOCKED = 2'd3} arb_state_e;
  function automatic logic [4:0] burst_beats(input hburst_e b);
    return (b == SINGLE) ? 5'd1 :
           (b == INCR) ? 5'd0 :
           (b == WRAP4 || b == INCR4) ? 5'd4 :
           (b == WRAP8 || b == INCR8) ? 5'd8 : 5'd16;
  endfunction
endpackage

// File: rtl/ahb_rr_prio_sel.sv
// ahb_rr_prio_sel: combinational round-robin picker searching upward from pointer+1
module ahb_rr_prio_sel #(
  parameter int NUM_MASTERS = 4,
  parameter int MID_W = $clog2(NUM_MASTERS)
) (
  input  logic [NUM_MASTERS-1:0] i_req,
  input  logic [MID_W-1:0]       i_ptr,
  output logic [NUM_MASTERS-1:0] o_gnt,
  output logic [MID_W-1:0]       o_idx,
  output logic                   o_valid
);
  logic [MID_W-1:0] w_j;
  always_comb begin
    o_idx = '0;
    o_valid = 1'b0;
    w_j = '0;
    for (int k = NUM_MASTERS; k >= 1; k--) begin
      w_j = MID_W'((int'(i_ptr) + k) % NUM_MASTERS);
      if (i_req[w_j]) begin
        o_idx = w_j;
        o_valid = 1'b1;
      end
    end
  end
  assign o_gnt = o_valid ? (NUM_MASTERS'(1) << o_idx) : '0;
endmodule

// File: rtl/ahb_bus_arbiter.sv
// ahb_bus_arbiter: round-robin AHB arbiter with burst, lock and error-aware handover
module ahb_bus_arbiter
  import ahb_pkg::*;
#(
  parameter int NUM_MASTERS = 4,
  parameter int DEFAULT_MASTER = 0,
  parameter int MID_W = $clog2(NUM_MASTERS)
) (
  input  logic                   hclk,
  input  logic                   hrst,
  input  logic [NUM_MASTERS-1:0] hbusreq,
  input  logic [NUM_MASTERS-1:0] hlock,
  input  logic [1:0]             htrans,
  input  logic [2:0]             hburst,
  input  logic                   hready,
  input  logic                   hresp,
  output logic [NUM_MASTERS-1:0] hgrant,
  output logic [MID_W-1:0]       hmaster,
  output logic                   hmastlock,
  output logic [1:0]             arb_state
);
  localparam logic [MID_W-1:0] DEF = MID_W'(DEFAULT_MASTER);
  localparam logic [NUM_MASTERS-1:0] DEF_OH = NUM_MASTERS'(1) << DEFAULT_MASTER;
  arb_state_e r_state, w_hold;
  logic [NUM_MASTERS-1:0] r_grant, w_win;
  logic [MID_W-1:0] r_idx, r_ptr, r_master, w_win_idx;
  logic [3:0] r_cnt, w_cnt_nxt;
  logic r_mastlock, r_err, r_tail;
  logic w_valid, w_own_req, w_own_lock, w_start, w_last, w_done, w_rearb;
  htrans_e w_tr;
  logic [4:0] w_beats;
  ahb_rr_prio_sel #(.NUM_MASTERS(NUM_MASTERS), .MID_W(MID_W)) u_sel (
    .i_req(hbusreq),
    .i_ptr(r_ptr),
    .o_gnt(w_win),
    .o_idx(w_win_idx),
    .o_valid(w_valid)
  );
  assign w_tr = htrans_e'(htrans);
  assign w_beats = burst_beats(hburst_e'(hburst));
  assign w_own_req = hbusreq[r_idx];
  assign w_own_lock = hlock[r_idx];
  assign w_start = (w_tr == NONSEQ) && (w_beats > 5'd1);
  assign w_last = (w_tr == SEQ) && (r_cnt == 4'd1);
  assign w_done = ((w_tr == NONSEQ) && (w_beats <= 5'd1)) || w_last;
  assign w_cnt_nxt = w_start ? 4'(w_beats - 5'd1) : (w_tr == SEQ && r_cnt != 4'd0) ? r_cnt - 4'd1 : r_cnt;
  assign w_rearb = (r_state == PARK) ||
                   (r_state == GRANT && !w_own_lock && !w_start && (w_tr == IDLE || !w_own_req)) ||
                   (r_state == BURST && (r_err || w_last)) ||
                   (r_state == LOCKED && (r_tail || !w_own_lock) && w_done);
  assign w_hold = (r_state == GRANT) ? (w_own_lock ? LOCKED : w_start ? BURST : GRANT) : r_state;
  always_ff @(posedge hclk) begin
    if (hrst) begin
      r_state <= PARK;
      r_grant <= DEF_OH;
      r_idx <= DEF;
      r_ptr <= DEF;
      r_master <= DEF;
      r_mastlock <= 1'b0;
      r_cnt <= '0;
      r_err <= 1'b0;
      r_tail <= 1'b0;
    end else if (!hready) begin
      if (r_state == BURST && hresp) r_err <= 1'b1;
    end else begin
      r_master <= r_idx;
      r_mastlock <= w_own_lock;
      r_err <= 1'b0;
      if (w_rearb) begin
        r_state <= w_valid ? GRANT : PARK;
        r_grant <= w_valid ? w_win : DEF_OH;
        r_idx <= w_valid ? w_win_idx : DEF;
        r_ptr <= w_valid ? w_win_idx : r_ptr;
        r_cnt <= '0;
        r_tail <= 1'b0;
      end else begin
        r_state <= w_hold;
        r_cnt <= w_cnt_nxt;
        r_tail <= (r_state == LOCKED) && (r_tail || !w_own_lock);
      end
    end
  end
  assign hgrant = r_grant;
  assign hmaster = r_master;
  assign hmastlock = r_mastlock;
  assign arb_state = r_state;
endmodule

// File: tb/tb_ahb_bus_arbiter.sv
// tb_ahb_bus_arbiter: directed checks of rotation, burst hold, wait states, lock and error handover
module tb_ahb_bus_arbiter;
  import ahb_pkg::*;
  logic hclk = 1'b0, hrst = 1'b1, hready = 1'b1, hresp = 1'b0, hmastlock;
  logic [3:0] hbusreq = 4'b1111, hlock = 4'b0000, hgrant;
  logic [1:0] htrans = 2'd0, hmaster, arb_state;
  logic [2:0] hburst = 3'd0;
  int n_chk = 0, n_fail = 0;
  always #5 hclk = ~hclk;
  ahb_bus_arbiter #(.NUM_MASTERS(4), .DEFAULT_MASTER(0)) dut (
    .hclk(hclk),
    .hrst(hrst),
    .hbusreq(hbusreq),
    .hlock(hlock),
    .htrans(htrans),
    .hburst(hburst),
    .hready(hready),
    .hresp(hresp),
    .hgrant(hgrant),
    .hmaster(hmaster),
    .hmastlock(hmastlock),
    .arb_state(arb_state)
  );
  task automatic chk(input string tag, input int got, input int exp);
    n_chk++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic cyc(input logic [3:0] req, input logic [3:0] lk, input htrans_e tr, input hburst_e hb, input logic rdy, input logic rsp);
    hbusreq = req;
    hlock = lk;
    htrans = tr;
    hburst = hb;
    hready = rdy;
    hresp = rsp;
    @(posedge hclk);
    #1;
  endtask
  task automatic burst_run(input int waits);
    htrans_e pat [9] = '{NONSEQ, SEQ, SEQ, BUSY, SEQ, SEQ, SEQ, SEQ, SEQ};
    for (int i = 0; i <= 8 + waits; i++) begin
      if (i >= 4 && i < 4 + waits) cyc(4'b0110, 4'b0000, SEQ, INCR8, 1'b0, 1'b0);
      else cyc(4'b0110, 4'b0000, pat[i < 4 ? i : i - waits], INCR8, 1'b1, 1'b0);
      chk($sformatf("burst_w%0d_c%0d_grant", waits, i), int'(hgrant), i == 8 + waits ? 4 : 2);
      if (i == 5) chk($sformatf("burst_w%0d_state", waits), int'(arb_state), 2);
    end
  endtask
  initial begin
    repeat (2) @(posedge hclk);
    #1;
    chk("rst_grant", int'(hgrant), 1);
    chk("rst_master", int'(hmaster), 0);
    chk("rst_lock", int'(hmastlock), 0);
    chk("rst_state", int'(arb_state), 0);
    hrst = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      cyc(4'b1111, 4'b0000, IDLE, SINGLE, 1'b1, 1'b0);
      chk($sformatf("rr%0d_grant", i), int'(hgrant), 1 << (i % 4));
      chk($sformatf("rr%0d_master_lag", i), int'(hmaster), i - 1);
      chk($sformatf("rr%0d_state", i), int'(arb_state), 1);
      cyc(4'b1111, 4'b0000, NONSEQ, SINGLE, 1'b1, 1'b0);
      chk($sformatf("rr%0d_master", i), int'(hmaster), i % 4);
    end
    cyc(4'b0110, 4'b0000, IDLE, SINGLE, 1'b1, 1'b0);
    chk("b8_setup_grant", int'(hgrant), 2);
    burst_run(0);
    cyc(4'b0010, 4'b0000, IDLE, SINGLE, 1'b1, 1'b0);
    chk("wait_setup_grant", int'(hgrant), 2);
    burst_run(3);
    cyc(4'b1101, 4'b0100, IDLE, SINGLE, 1'b1, 1'b0);
    chk("lock_enter_state", int'(arb_state), 3);
    for (int b = 0; b < 2; b++)
      for (int k = 0; k < 4; k++) begin
        cyc(4'b1101, 4'b0100, k == 0 ? NONSEQ : SEQ, INCR4, 1'b1, 1'b0);
        chk($sformatf("lock_b%0d_k%0d_grant", b, k), int'(hgrant), 4);
      end
    chk("lock_mastlock", int'(hmastlock), 1);
    chk("lock_master", int'(hmaster), 2);
    cyc(4'b1101, 4'b0000, IDLE, SINGLE, 1'b1, 1'b0);
    chk("unlock_hold_grant", int'(hgrant), 4);
    chk("unlock_hold_state", int'(arb_state), 3);
    cyc(4'b1101, 4'b0000, NONSEQ, SINGLE, 1'b1, 1'b0);
    chk("unlock_handover", int'(hgrant), 8);
    cyc(4'b0011, 4'b0000, IDLE, SINGLE, 1'b1, 1'b0);
    chk("err_setup_grant", int'(hgrant), 1);
    cyc(4'b0011, 4'b0000, NONSEQ, INCR16, 1'b1, 1'b0);
    chk("err_burst_state", int'(arb_state), 2);
    repeat (3) cyc(4'b0011, 4'b0000, SEQ, INCR16, 1'b1, 1'b0);
    cyc(4'b0011, 4'b0000, SEQ, INCR16, 1'b0, 1'b1);
    chk("err_first_grant", int'(hgrant), 1);
    cyc(4'b0011, 4'b0000, IDLE, INCR16, 1'b1, 1'b1);
    chk("err_rearb_grant", int'(hgrant), 2);
    chk("err_rearb_state", int'(arb_state), 1);
    cyc(4'b0000, 4'b0000, IDLE, SINGLE, 1'b1, 1'b0);
    chk("park_grant", int'(hgrant), 1);
    chk("park_state", int'(arb_state), 0);
    chk("park_master_lag", int'(hmaster), 1);
    cyc(4'b0000, 4'b0000, IDLE, SINGLE, 1'b1, 1'b0);
    chk("park_master", int'(hmaster), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
